dec_timer: RTL and testbench

//  Loadable down-counter and timer; the countdown counterpart to the up-counter.

---
 rtl/dec_timer_if.sv | 50 +++++
 rtl/dec_timer.sv | 129 ++++++++++++
 tb/tb_dec_timer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_timer_if.sv
// Bus bundle for dec_timer: control/load inputs and count/status outputs.
// When AUTO_RELOAD_EN is defined the auto_reload control is added to the bundle.
interface dec_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             enable;
`ifdef AUTO_RELOAD_EN
    logic             auto_reload;
`endif
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    // Controller side: drives commands, observes count and status
    modport master (
        output load,
        output load_val,
        output start,
        output stop,
        output enable,
`ifdef AUTO_RELOAD_EN
        output auto_reload,
`endif
        input  count,
        input  tc,
        input  busy,
        input  done
    );

    // Timer side: receives commands, reports count and status
    modport slave (
        input  load,
        input  load_val,
        input  start,
        input  stop,
        input  enable,
`ifdef AUTO_RELOAD_EN
        input  auto_reload,
`endif
        output count,
        output tc,
        output busy,
        output done
    );
endinterface

// File: rtl/dec_timer.sv
// dec_timer: loadable down-counter / timer with terminal-count pulse.
// States IDLE/RUN/DONE; count decrements on enable while RUN, tc pulses for one
// cycle on the 1->0 transition, then the block parks in DONE.
// Optional feature macro: AUTO_RELOAD_EN -- when defined, terminal count with
// auto_reload=1 (and a non-zero reload value) reloads the count and stays in RUN.
module dec_timer #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    dec_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             auto_reload_w;

`ifdef AUTO_RELOAD_EN
    assign auto_reload_w = bus.auto_reload;
`else
    assign auto_reload_w = 1'b0;
`endif

    // Saturating decrement: the count must never wrap below zero
    function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
        return (v == ZERO) ? ZERO : (v - ONE);
    endfunction

    // Next-state, next-count and status decode; priority load > stop > start > enable
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            // Load from any state aborts a countdown without a tc pulse
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Resume from the current count, so a paused countdown continues
                    if (bus.start) begin
                        if (count_q != ZERO) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_d = S_IDLE;
                    end else if (bus.enable) begin
                        if (count_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload_w && (reload_q != ZERO)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                state_d = S_DONE;
                            end
                        end else begin
                            count_d = dec_sat(count_q);
                        end
                    end
                end
                S_DONE: begin
                    // Restart from the reload value; a zero reload re-fires tc immediately
                    if (bus.start) begin
                        count_d = reload_q;
                        if (reload_q != ZERO) begin
                            state_d = S_RUN;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, count, reload and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_dec_timer.sv
// Directed testbench for dec_timer (default build; auto-reload scenario only
// when AUTO_RELOAD_EN is defined).
module tb_dec_timer;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dec_timer_if #(.WIDTH(WIDTH)) bus ();

    dec_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.enable   = 1'b0;
`ifdef AUTO_RELOAD_EN
        bus.auto_reload = 1'b0;
`endif
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        bus.load = 1'b1; bus.load_val = v;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs(); tick(); tick(); reset = 1'b0;
        checks++;
        if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            errors++; $display("FAIL reset_init: count=%0d busy=%b done=%b tc=%b expected 0 0 0 0", bus.count, bus.busy, bus.done, bus.tc);
        end
        // Reset in the middle of a countdown
        do_load(8'd5);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.count !== 8'd5) begin
            errors++; $display("FAIL reset_prerun: busy=%b count=%0d expected 1 5", bus.busy, bus.count);
        end
        reset = 1'b1; tick();
        checks++;
        if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            errors++; $display("FAIL reset_midrun: count=%0d busy=%b done=%b tc=%b expected 0 0 0 0", bus.count, bus.busy, bus.done, bus.tc);
        end
        tick(); reset = 1'b0;
    endtask

    task automatic test_basic_countdown();
        logic [WIDTH-1:0] exp_cnt [3] = '{8'd2, 8'd1, 8'd0};
        do_load(8'd3);
        checks++;
        if (bus.count !== 8'd3 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_load: count=%0d busy=%b expected 3 0", bus.count, bus.busy);
        end
        bus.start = 1'b1; bus.enable = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.count !== 8'd3 || bus.tc !== 1'b0) begin
            errors++; $display("FAIL basic_start: busy=%b count=%0d tc=%b expected 1 3 0", bus.busy, bus.count, bus.tc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.count !== exp_cnt[i] || bus.tc !== (i == 2)) begin
                errors++; $display("FAIL basic_step%0d: count=%0d tc=%b expected %0d %b", i, bus.count, bus.tc, exp_cnt[i], (i == 2));
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_term_state: done=%b busy=%b expected 1 0", bus.done, bus.busy);
        end
        tick();
        checks++;
        if (bus.tc !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'd0) begin
            errors++; $display("FAIL basic_after: tc=%b done=%b busy=%b count=%0d expected 0 1 0 0", bus.tc, bus.done, bus.busy, bus.count);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_enable_toggle();
        // After start: enable pattern 1,0 repeated; count 6 drops on each enable cycle
        logic [WIDTH-1:0] exp_cnt [12] = '{8'd5, 8'd5, 8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
        logic             exp_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int bad;
        bad = 0;
        do_load(8'd6);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.enable = (i % 2 == 0);
            tick();
            if (bus.count !== exp_cnt[i] || bus.tc !== exp_tc[i]) begin
                bad++; $display("FAIL toggle_step%0d: count=%0d tc=%b expected %0d %b", i, bus.count, bus.tc, exp_cnt[i], exp_tc[i]);
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL toggle_done: done=%b expected 1", bus.done);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_stop_resume();
        do_load(8'd5);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.enable = 1'b1; tick(); tick();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        checks++;
        if (bus.count !== 8'd3 || bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL stop_hold: count=%0d busy=%b tc=%b done=%b expected 3 0 0 0", bus.count, bus.busy, bus.tc, bus.done);
        end
        // Enable while paused must not move the count
        tick();
        checks++;
        if (bus.count !== 8'd3) begin
            errors++; $display("FAIL stop_idle_enable: count=%0d expected 3", bus.count);
        end
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.count !== 8'd3) begin
            errors++; $display("FAIL resume_start: busy=%b count=%0d expected 1 3", bus.busy, bus.count);
        end
        tick(); tick();
        checks++;
        if (bus.count !== 8'd1 || bus.tc !== 1'b0) begin
            errors++; $display("FAIL resume_mid: count=%0d tc=%b expected 1 0", bus.count, bus.tc);
        end
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.tc !== 1'b1 || bus.done !== 1'b1) begin
            errors++; $display("FAIL resume_tc: count=%0d tc=%b done=%b expected 0 1 1", bus.count, bus.tc, bus.done);
        end
        // Load during RUN aborts with no tc
        do_load(8'd4);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(); tick();
        checks++;
        if (bus.count !== 8'd2 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre: count=%0d busy=%b expected 2 1", bus.count, bus.busy);
        end
        bus.load = 1'b1; bus.load_val = 8'd9; bus.start = 1'b1; tick();
        bus.load = 1'b0; bus.start = 1'b0;
        checks++;
        if (bus.count !== 8'd9 || bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort_load: count=%0d busy=%b tc=%b done=%b expected 9 0 0 0", bus.count, bus.busy, bus.tc, bus.done);
        end
        // Start while RUN is ignored (count keeps decrementing); stop beats start
        bus.start = 1'b1; tick(); tick();
        checks++;
        if (bus.count !== 8'd8 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL run_start_ignored: count=%0d busy=%b expected 8 1", bus.count, bus.busy);
        end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0; bus.start = 1'b0;
        checks++;
        if (bus.count !== 8'd8 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL stop_over_start: count=%0d busy=%b expected 8 0", bus.count, bus.busy);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_zero_load();
        do_load(8'd0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.tc !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'd0) begin
            errors++; $display("FAIL zero_start: done=%b tc=%b busy=%b count=%0d expected 1 1 0 0", bus.done, bus.tc, bus.busy, bus.count);
        end
        tick();
        checks++;
        if (bus.tc !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL zero_after: tc=%b done=%b busy=%b expected 0 1 0", bus.tc, bus.done, bus.busy);
        end
        // Restart from DONE with a zero reload pulses tc and stays DONE
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL zero_restart: tc=%b done=%b busy=%b expected 1 1 0", bus.tc, bus.done, bus.busy);
        end
    endtask

    task automatic test_full_range();
        int bad;
        bad = 0;
        do_load(8'd255);
        bus.enable = 1'b1; bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.count !== 8'd255 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL full_start: count=%0d busy=%b expected 255 1", bus.count, bus.busy);
        end
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (bus.count !== 8'(255 - i) || bus.tc !== (i == 255)) begin
                if (bad < 4) $display("FAIL full_tick%0d: count=%0d tc=%b expected %0d %b", i, bus.count, bus.tc, 255 - i, (i == 255));
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.tc !== 1'b0 || bus.done !== 1'b1) begin
            errors++; $display("FAIL full_nowrap: count=%0d tc=%b done=%b expected 0 0 1", bus.count, bus.tc, bus.done);
        end
        // DONE + start with a non-zero reload restarts from the reload value
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.count !== 8'd255 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            errors++; $display("FAIL done_restart: count=%0d busy=%b done=%b tc=%b expected 255 1 0 0", bus.count, bus.busy, bus.done, bus.tc);
        end
        bus.enable = 1'b0;
        do_load(8'd0);
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [WIDTH-1:0] exp_cnt [8] = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
        do_load(8'd4);
        bus.auto_reload = 1'b1; bus.enable = 1'b1; bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.count !== exp_cnt[i] || bus.tc !== (i % 4 == 3) || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL auto_step%0d: count=%0d tc=%b done=%b busy=%b expected %0d %b 0 1", i, bus.count, bus.tc, bus.done, bus.busy, exp_cnt[i], (i % 4 == 3));
            end
        end
        bus.auto_reload = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (bus.count !== 8'd0 || bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL auto_off: count=%0d tc=%b done=%b busy=%b expected 0 1 1 0", bus.count, bus.tc, bus.done, bus.busy);
        end
        bus.enable = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_countdown();
        test_enable_toggle();
        test_stop_resume();
        test_zero_load();
        test_full_range();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
